// File: rtl/temporal_pkg.sv
// Shared types and helpers for the clocked race-logic GE comparator array.
package temporal_pkg;

  // Input/output encoding selected per gamma cycle.
  typedef enum logic [1:0] {
    TM_RISING  = 2'b00,
    TM_FALLING = 2'b01,
    TM_PULSE   = 2'b10,
    TM_RSVD    = 2'b11
  } tmode_e;

  // All-ones value of the given width, used as the "no event" time.
  function automatic logic [31:0] time_inf(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

  // Input level that marks an event: low for FALLING, high otherwise.
  function automatic logic evt_level(input tmode_e m);
    return (m != TM_FALLING);
  endfunction

endpackage

// File: rtl/temporal_ge_array_ge_channel.sv
// One race-logic GE comparator channel: q fires at t_a only when t_a >= t_b.
// Ports: clk, rst (sync, active high), clr (gamma start strobe), busy,
//        last_c (final sample of the window), k (sample index),
//        mode (registered encoding), mode_nx (encoding latched by clr),
//        a/b (event inputs), q (encoded output), t_q (output event time).
module ge_channel
  import temporal_pkg::*;
#(
  parameter int unsigned TW          = 5,
  parameter int unsigned PULSE_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          busy,
  input  logic          last_c,
  input  logic [TW-1:0] k,
  input  tmode_e        mode,
  input  tmode_e        mode_nx,
  input  logic          a,
  input  logic          b,
  output logic          q,
  output logic [TW-1:0] t_q
);

  localparam int unsigned PCW = $clog2(PULSE_WIDTH + 1);
  localparam logic [TW-1:0] TINF = TW'(time_inf(TW));

  logic           a_seen, b_seen, inhibited, fired;
  logic [PCW-1:0] pcnt, pcnt_nx;
  logic           lvl, a_evt, b_evt, fire, fired_now, q_nx;

  // First-event detection; a same-sample b event counts as already seen (ties pass).
  always_comb begin
    lvl       = evt_level(mode);
    a_evt     = busy && !a_seen && (a == lvl);
    b_evt     = busy && !b_seen && (b == lvl);
    fire      = a_evt && !inhibited && (b_seen || b_evt);
    fired_now = fired || fire;
  end

  // Output encoding; forced low on the final sample so q is 0 once busy drops.
  always_comb begin
    q_nx    = 1'b0;
    pcnt_nx = '0;
    if (busy && !last_c) begin
      case (mode)
        TM_FALLING: q_nx = !fired_now;
        TM_PULSE:   q_nx = fire || (pcnt != '0);
        default:    q_nx = fired_now;
      endcase
      if (fire)             pcnt_nx = PCW'(PULSE_WIDTH - 1);
      else if (pcnt != '0)  pcnt_nx = pcnt - PCW'(1);
    end
  end

  // Per-channel state; clr also presets q high for FALLING windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_seen    <= 1'b0;
      b_seen    <= 1'b0;
      inhibited <= 1'b0;
      fired     <= 1'b0;
      t_q       <= TINF;
      pcnt      <= '0;
      q         <= 1'b0;
    end else if (clr) begin
      a_seen    <= 1'b0;
      b_seen    <= 1'b0;
      inhibited <= 1'b0;
      fired     <= 1'b0;
      t_q       <= TINF;
      pcnt      <= '0;
      q         <= (mode_nx == TM_FALLING);
    end else begin
      if (a_evt)         a_seen    <= 1'b1;
      if (b_evt)         b_seen    <= 1'b1;
      if (a_evt && !fire) inhibited <= 1'b1;
      if (fire) begin
        fired <= 1'b1;
        t_q   <= k;
      end
      q    <= q_nx;
      pcnt <= pcnt_nx;
    end
  end

endmodule

// File: rtl/temporal_ge_array.sv
// Clocked multi-channel race-logic GE array with gamma-cycle windowing.
// Ports: clk, rst (sync, active high), gamma_start (start/restart pulse),
//        mode (encoding, sampled on gamma_start), a/b (per-channel events),
//        q (per-channel output), t_q (per-channel event time, all-ones = none),
//        busy (window active), done (one-cycle pulse after the last sample).
module temporal_ge_array
  import temporal_pkg::*;
#(
  parameter int unsigned N_CH              = 4,
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             gamma_start,
  input  logic [1:0]                                       mode,
  input  logic [N_CH-1:0]                                  a,
  input  logic [N_CH-1:0]                                  b,
  output logic [N_CH-1:0]                                  q,
  output logic [N_CH*$clog2(GAMMA_CYCLE_WIDTH+1)-1:0]      t_q,
  output logic                                             busy,
  output logic                                             done
);

  localparam int unsigned TW = $clog2(GAMMA_CYCLE_WIDTH + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e        state, state_d;
  logic [TW-1:0] cnt, cnt_d;
  tmode_e        mode_q, mode_d, mode_nx;
  logic          done_d, last_c;

  assign busy    = (state == ST_BUSY);
  assign last_c  = busy && (cnt == TW'(GAMMA_CYCLE_WIDTH - 1));
  // Reserved encoding behaves as RISING.
  assign mode_nx = (tmode_e'(mode) == TM_RSVD) ? TM_RISING : tmode_e'(mode);

  // Window control: gamma_start (re)starts, the last sample ends with done.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (gamma_start) begin
      state_d = ST_BUSY;
      cnt_d   = '0;
      mode_d  = mode_nx;
    end else if (state == ST_BUSY) begin
      if (last_c) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= TM_RISING;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      mode_q <= mode_d;
      done   <= done_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ge_channel #(
      .TW          (TW),
      .PULSE_WIDTH (PULSE_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clr     (gamma_start),
      .busy    (busy),
      .last_c  (last_c),
      .k       (cnt),
      .mode    (mode_q),
      .mode_nx (mode_nx),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .t_q     (t_q[i*TW +: TW])
    );
  end

endmodule
